param_rob: RTL and testbench
============================

PARAM_ROB -- requirements
Module: param_rob

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, at least 4.
REQ-002 Parameter NUM_WB, default 2, number of writeback ports.
REQ-003 Parameter XLEN, default 32, data/PC width; TW = log2(DEPTH) is the tag width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset: synchronous, active-high; clock clk.
REQ-006 rdy  in  1  global enable; when low, state holds and pulse outputs deassert.
REQ-007 disp_valid/disp_rd/disp_pc/disp_is_br/disp_is_st/disp_pred  in  1/5/XLEN/1/1/1  dispatch request and fields.
REQ-008 disp_ready  out  1  combinational; high when count < DEPTH and no flush is pending.
REQ-009 disp_tag  out  TW  combinational; tag (tail index) the next accepted entry receives.
REQ-010 wb_valid/wb_tag/wb_res/wb_taken/wb_target  in  NUM_WB x (1/TW/XLEN/1/XLEN)  packed writeback ports.
REQ-011 qj_tag/qk_tag  in  TW each; qj_rdy/qk_rdy  out  1; qj_val/qk_val  out  XLEN  combinational operand lookup.
REQ-012 commit_valid/commit_rd/commit_res/commit_tag  out  1/5/XLEN/TW  registered retire pulse to the register file.
REQ-013 st_commit_valid/st_commit_tag  out  1/TW  registered pulse releasing a store to the LSB.
REQ-014 flush/flush_pc  out  1/XLEN  registered mispredict redirect.
REQ-015 bp_upd_valid/bp_upd_pc/bp_upd_taken  out  1/XLEN/1  registered predictor update.

Function
REQ-016 Circular buffer with head, tail (TW bits, natural wrap) and count (TW+1 bits); empty = count 0; full = count DEPTH; all DEPTH entries are usable.
REQ-017 Dispatch fires when disp_valid and disp_ready and rdy; the entry at tail is written not-ready and tail increments.
REQ-018 Each writeback with wb_valid sets ready, res, taken and target of entry wb_tag; a writeback to an invalid entry is ignored.
REQ-019 For a lookup, rdy = entry ready or a same-cycle wb_valid matching the tag; val is forwarded from that writeback, with the lowest-numbered port winning.
REQ-020 Retire: when the head entry is valid and ready and rdy, exactly one entry retires per cycle; head increments and count decrements.
REQ-021 A retiring non-store entry with rd != 0 pulses commit_valid for one cycle; a retiring store pulses st_commit_valid with its tag, and commit_valid stays low.
REQ-022 A retiring branch pulses bp_upd_valid with its pc and resolved taken.
REQ-023 If the branch's taken != pred, flush pulses for one cycle with flush_pc = target if taken, else pc+4.
REQ-024 On the cycle after a flush pulse, all entries are invalidated, head = tail = count = 0, and dispatch and writebacks are ignored.
REQ-025 Simultaneous dispatch and retire leave count unchanged; dispatch to a full buffer is impossible because disp_ready is low.
REQ-026 A writeback and a retire of the same entry in the same cycle: the retire waits until the next cycle.
REQ-027 Latency: a writeback landing at cycle N permits retire at N+1, with the commit pulse visible at N+2.

Reset
REQ-028 On rst: head, tail and count = 0, all valid/ready bits = 0, every output register (commit_*, st_commit_*, flush, flush_pc, bp_upd_*) = 0.
REQ-029 rst mid-operation discards all in-flight entries; disp_ready is high the cycle after rst releases.

Structure
REQ-030 The shared package holds the ROB entry struct (valid, ready, rd, pc, res, is_br, is_st, pred, taken, target) and the DEPTH/XLEN defaults.
REQ-031 One sub-module, rob_wb_match, performs the NUM_WB-port tag match and priority mux for the lookup and writeback paths.

Verification
REQ-032 Fill: 16 dispatches with no writebacks -> disp_ready is low after the 16th and disp_tag wraps from 15 to 0 after retirement.
REQ-033 Out-of-order writeback of tags 2, 1, 0 at cycles 5, 6, 7 -> commits of tags 0, 1, 2 in consecutive cycles starting at cycle 9.
REQ-034 Lookup of qj_tag = 3 while port 1 writes tag 3 with res 0xDEADBEEF in the same cycle -> qj_rdy = 1 and qj_val = 0xDEADBEEF.
REQ-035 Branch at pc 0x100 with pred 0, writeback taken = 1 and target 0x200 -> flush with flush_pc 0x200 and bp_upd_taken 1; younger entries are never committed; count = 0.
REQ-036 Store at head, made ready -> st_commit_valid pulses with its tag and commit_valid stays 0.
REQ-037 rst asserted with 5 entries in flight -> all outputs 0 on the next cycle and disp_tag = 0.

Source files
------------

// File: rtl/param_rob_pkg.sv
// ============================================================================
// Module  : param_rob_pkg
// Brief   : Shared types and defaults for the parameterised reorder buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package param_rob_pkg;

    localparam int ROB_DEPTH_DEF = 16;
    localparam int ROB_XLEN_DEF  = 32;
    // Data fields are stored at the widest supported XLEN and narrowed on read.
    localparam int ROB_XLEN_MAX  = 64;

    typedef struct packed {
        logic                    valid;
        logic                    ready;
        logic [4:0]              rd;
        logic [ROB_XLEN_MAX-1:0] pc;
        logic [ROB_XLEN_MAX-1:0] res;
        logic                    is_br;
        logic                    is_st;
        logic                    pred;
        logic                    taken;
        logic [ROB_XLEN_MAX-1:0] target;
    } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/param_rob_wb_match.sv
// ============================================================================
// Module  : rob_wb_match
// Brief   : Matches one tag against all writeback ports; lowest port wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_wb_match #(
    parameter int NUM_WB = 2,
    parameter int TW     = 4,
    parameter int XLEN   = 32,
    localparam int PW    = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
    input  logic [NUM_WB-1:0]      wb_valid_i,
    input  logic [NUM_WB*TW-1:0]   wb_tag_i,
    input  logic [NUM_WB*XLEN-1:0] wb_res_i,
    input  logic [TW-1:0]          tag_i,
    output logic                   hit_o,
    output logic [XLEN-1:0]        res_o,
    output logic [PW-1:0]          sel_o
);

    // Scan from the highest port down so the lowest matching port overrides.
    always_comb begin
        hit_o = 1'b0;
        res_o = '0;
        sel_o = '0;
        for (int p = NUM_WB - 1; p >= 0; p--) begin
            if (wb_valid_i[p] && (wb_tag_i[p*TW +: TW] == tag_i)) begin
                hit_o = 1'b1;
                res_o = wb_res_i[p*XLEN +: XLEN];
                sel_o = PW'(p);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/param_rob.sv
// ============================================================================
// Module  : param_rob
// Brief   : Parameterised reorder buffer with in-order retire and flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module param_rob
    import param_rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH_DEF,
    parameter int NUM_WB = 2,
    parameter int XLEN   = ROB_XLEN_DEF,
    localparam int TW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   disp_valid,
    input  logic [4:0]             disp_rd,
    input  logic [XLEN-1:0]        disp_pc,
    input  logic                   disp_is_br,
    input  logic                   disp_is_st,
    input  logic                   disp_pred,
    output logic                   disp_ready,
    output logic [TW-1:0]          disp_tag,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*TW-1:0]   wb_tag,
    input  logic [NUM_WB*XLEN-1:0] wb_res,
    input  logic [NUM_WB-1:0]      wb_taken,
    input  logic [NUM_WB*XLEN-1:0] wb_target,
    input  logic [TW-1:0]          qj_tag,
    input  logic [TW-1:0]          qk_tag,
    output logic                   qj_rdy,
    output logic                   qk_rdy,
    output logic [XLEN-1:0]        qj_val,
    output logic [XLEN-1:0]        qk_val,
    output logic                   commit_valid,
    output logic [4:0]             commit_rd,
    output logic [XLEN-1:0]        commit_res,
    output logic [TW-1:0]          commit_tag,
    output logic                   st_commit_valid,
    output logic [TW-1:0]          st_commit_tag,
    output logic                   flush,
    output logic [XLEN-1:0]        flush_pc,
    output logic                   bp_upd_valid,
    output logic [XLEN-1:0]        bp_upd_pc,
    output logic                   bp_upd_taken
);

    localparam int PW = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    rob_entry_t        entries_q [DEPTH];
    rob_entry_t        entries_d [DEPTH];
    logic [TW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [TW:0]       count_q, count_d;

    logic              commit_valid_q, commit_valid_d;
    logic [4:0]        commit_rd_q, commit_rd_d;
    logic [XLEN-1:0]   commit_res_q, commit_res_d;
    logic [TW-1:0]     commit_tag_q, commit_tag_d;
    logic              st_commit_valid_q, st_commit_valid_d;
    logic [TW-1:0]     st_commit_tag_q, st_commit_tag_d;
    logic              flush_q, flush_d;
    logic [XLEN-1:0]   flush_pc_q, flush_pc_d;
    logic              bp_upd_valid_q, bp_upd_valid_d;
    logic [XLEN-1:0]   bp_upd_pc_q, bp_upd_pc_d;
    logic              bp_upd_taken_q, bp_upd_taken_d;

    logic [DEPTH-1:0]  wb_hit;
    logic [XLEN-1:0]   wb_res_m [DEPTH];
    logic [PW-1:0]     wb_sel   [DEPTH];

    logic              qj_hit, qk_hit;
    logic [XLEN-1:0]   qj_fwd, qk_fwd;
    logic [PW-1:0]     qj_sel_unused, qk_sel_unused;

    rob_entry_t        head_e;
    logic              full, disp_fire, ret_fire;

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        rob_wb_match #(.NUM_WB(NUM_WB), .TW(TW), .XLEN(XLEN)) u_match (
            .wb_valid_i (wb_valid),
            .wb_tag_i   (wb_tag),
            .wb_res_i   (wb_res),
            .tag_i      (TW'(e)),
            .hit_o      (wb_hit[e]),
            .res_o      (wb_res_m[e]),
            .sel_o      (wb_sel[e])
        );
    end

    rob_wb_match #(.NUM_WB(NUM_WB), .TW(TW), .XLEN(XLEN)) u_qj_match (
        .wb_valid_i (wb_valid),
        .wb_tag_i   (wb_tag),
        .wb_res_i   (wb_res),
        .tag_i      (qj_tag),
        .hit_o      (qj_hit),
        .res_o      (qj_fwd),
        .sel_o      (qj_sel_unused)
    );

    rob_wb_match #(.NUM_WB(NUM_WB), .TW(TW), .XLEN(XLEN)) u_qk_match (
        .wb_valid_i (wb_valid),
        .wb_tag_i   (wb_tag),
        .wb_res_i   (wb_res),
        .tag_i      (qk_tag),
        .hit_o      (qk_hit),
        .res_o      (qk_fwd),
        .sel_o      (qk_sel_unused)
    );

    assign full       = (count_q == (TW+1)'(DEPTH));
    assign disp_ready = !full && !flush_q;
    assign disp_tag   = tail_q;
    assign disp_fire  = disp_valid && disp_ready && rdy;
    assign head_e     = entries_q[head_q];
    // Retire looks only at the registered ready bit, so a same-cycle writeback waits a cycle.
    assign ret_fire   = rdy && !flush_q && head_e.valid && head_e.ready;

    assign qj_rdy = qj_hit || (entries_q[qj_tag].valid && entries_q[qj_tag].ready);
    assign qk_rdy = qk_hit || (entries_q[qk_tag].valid && entries_q[qk_tag].ready);
    assign qj_val = qj_hit ? qj_fwd : XLEN'(entries_q[qj_tag].res);
    assign qk_val = qk_hit ? qk_fwd : XLEN'(entries_q[qk_tag].res);

    always_comb begin
        entries_d         = entries_q;
        head_d            = head_q;
        tail_d            = tail_q;
        count_d           = count_q;
        commit_valid_d    = 1'b0;
        commit_rd_d       = commit_rd_q;
        commit_res_d      = commit_res_q;
        commit_tag_d      = commit_tag_q;
        st_commit_valid_d = 1'b0;
        st_commit_tag_d   = st_commit_tag_q;
        flush_d           = 1'b0;
        flush_pc_d        = flush_pc_q;
        bp_upd_valid_d    = 1'b0;
        bp_upd_pc_d       = bp_upd_pc_q;
        bp_upd_taken_d    = bp_upd_taken_q;

        // A pending flush clears the buffer even while rdy is low, so it is never lost.
        if (flush_q) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].ready = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_hit[i] && entries_q[i].valid) begin
                    entries_d[i].ready  = 1'b1;
                    entries_d[i].res    = ROB_XLEN_MAX'(wb_res_m[i]);
                    entries_d[i].taken  = wb_taken[wb_sel[i]];
                    entries_d[i].target = ROB_XLEN_MAX'(wb_target[wb_sel[i]*XLEN +: XLEN]);
                end
            end

            if (ret_fire) begin
                entries_d[head_q].valid = 1'b0;
                entries_d[head_q].ready = 1'b0;
                head_d            = head_q + 1'b1;
                commit_valid_d    = !head_e.is_st && (head_e.rd != 5'd0);
                commit_rd_d       = head_e.rd;
                commit_res_d      = XLEN'(head_e.res);
                commit_tag_d      = head_q;
                st_commit_valid_d = head_e.is_st;
                st_commit_tag_d   = head_q;
                bp_upd_valid_d    = head_e.is_br;
                bp_upd_pc_d       = XLEN'(head_e.pc);
                bp_upd_taken_d    = head_e.taken;
                flush_d           = head_e.is_br && (head_e.taken != head_e.pred);
                flush_pc_d        = head_e.taken ? XLEN'(head_e.target)
                                                 : XLEN'(head_e.pc) + XLEN'(4);
            end

            if (disp_fire) begin
                entries_d[tail_q].valid  = 1'b1;
                entries_d[tail_q].ready  = 1'b0;
                entries_d[tail_q].rd     = disp_rd;
                entries_d[tail_q].pc     = ROB_XLEN_MAX'(disp_pc);
                entries_d[tail_q].res    = '0;
                entries_d[tail_q].is_br  = disp_is_br;
                entries_d[tail_q].is_st  = disp_is_st;
                entries_d[tail_q].pred   = disp_pred;
                entries_d[tail_q].taken  = 1'b0;
                entries_d[tail_q].target = '0;
                tail_d = tail_q + 1'b1;
            end

            count_d = count_q + (TW+1)'(disp_fire) - (TW+1)'(ret_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            commit_valid_q    <= 1'b0;
            commit_rd_q       <= '0;
            commit_res_q      <= '0;
            commit_tag_q      <= '0;
            st_commit_valid_q <= 1'b0;
            st_commit_tag_q   <= '0;
            flush_q           <= 1'b0;
            flush_pc_q        <= '0;
            bp_upd_valid_q    <= 1'b0;
            bp_upd_pc_q       <= '0;
            bp_upd_taken_q    <= 1'b0;
        end else begin
            entries_q         <= entries_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            commit_valid_q    <= commit_valid_d;
            commit_rd_q       <= commit_rd_d;
            commit_res_q      <= commit_res_d;
            commit_tag_q      <= commit_tag_d;
            st_commit_valid_q <= st_commit_valid_d;
            st_commit_tag_q   <= st_commit_tag_d;
            flush_q           <= flush_d;
            flush_pc_q        <= flush_pc_d;
            bp_upd_valid_q    <= bp_upd_valid_d;
            bp_upd_pc_q       <= bp_upd_pc_d;
            bp_upd_taken_q    <= bp_upd_taken_d;
        end
    end

    assign commit_valid    = commit_valid_q;
    assign commit_rd       = commit_rd_q;
    assign commit_res      = commit_res_q;
    assign commit_tag      = commit_tag_q;
    assign st_commit_valid = st_commit_valid_q;
    assign st_commit_tag   = st_commit_tag_q;
    assign flush           = flush_q;
    assign flush_pc        = flush_pc_q;
    assign bp_upd_valid    = bp_upd_valid_q;
    assign bp_upd_pc       = bp_upd_pc_q;
    assign bp_upd_taken    = bp_upd_taken_q;

endmodule

`default_nettype wire

// File: tb/tb_param_rob.sv
// ============================================================================
// Module  : tb_param_rob
// Brief   : Self-checking bench for param_rob against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_rob;

    localparam int DEPTH  = 16;
    localparam int NUM_WB = 2;
    localparam int XLEN   = 32;
    localparam int TW     = 4;

    logic                   clk = 1'b0;
    logic                   rst, rdy;
    logic                   disp_valid, disp_is_br, disp_is_st, disp_pred;
    logic [4:0]             disp_rd;
    logic [XLEN-1:0]        disp_pc;
    logic                   disp_ready;
    logic [TW-1:0]          disp_tag;
    logic [NUM_WB-1:0]      wb_valid, wb_taken;
    logic [NUM_WB*TW-1:0]   wb_tag;
    logic [NUM_WB*XLEN-1:0] wb_res, wb_target;
    logic [TW-1:0]          qj_tag, qk_tag;
    logic                   qj_rdy, qk_rdy;
    logic [XLEN-1:0]        qj_val, qk_val;
    logic                   commit_valid, st_commit_valid, flush, bp_upd_valid, bp_upd_taken;
    logic [4:0]             commit_rd;
    logic [XLEN-1:0]        commit_res, flush_pc, bp_upd_pc;
    logic [TW-1:0]          commit_tag, st_commit_tag;

    param_rob #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_pc(disp_pc),
        .disp_is_br(disp_is_br), .disp_is_st(disp_is_st), .disp_pred(disp_pred),
        .disp_ready(disp_ready), .disp_tag(disp_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_res(wb_res),
        .wb_taken(wb_taken), .wb_target(wb_target),
        .qj_tag(qj_tag), .qk_tag(qk_tag), .qj_rdy(qj_rdy), .qk_rdy(qk_rdy),
        .qj_val(qj_val), .qk_val(qk_val),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_res(commit_res), .commit_tag(commit_tag),
        .st_commit_valid(st_commit_valid), .st_commit_tag(st_commit_tag),
        .flush(flush), .flush_pc(flush_pc),
        .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc), .bp_upd_taken(bp_upd_taken)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: in-flight instructions as an age-ordered queue, oldest first.
    typedef struct {
        int         tag;
        logic [4:0] rd;
        logic [31:0] pc;
        bit         is_br, is_st, pred, ready, taken;
        logic [31:0] res, target;
    } ment_t;

    ment_t       mq[$];
    int          m_tail = 0;
    ment_t       m_h, m_t;
    bit          m_can_disp, m_ret, m_dup;
    bit          e_cv, e_scv, e_fl, e_bpv, e_bpt;
    logic [4:0]  e_crd;
    logic [31:0] e_cres, e_flpc, e_bppc;
    int          e_ctag, e_stag;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_tail = 0;
            e_cv = 0; e_scv = 0; e_fl = 0; e_bpv = 0; e_bpt = 0;
            e_crd = 0; e_cres = 0; e_flpc = 0; e_bppc = 0; e_ctag = 0; e_stag = 0;
        end else if (e_fl) begin
            mq.delete();
            m_tail = 0;
            e_cv = 0; e_scv = 0; e_fl = 0; e_bpv = 0;
        end else if (!rdy) begin
            e_cv = 0; e_scv = 0; e_fl = 0; e_bpv = 0;
        end else begin
            m_can_disp = mq.size() < DEPTH;
            m_ret = (mq.size() > 0) && mq[0].ready;
            if (m_ret) m_h = mq[0];
            e_cv = 0; e_scv = 0; e_fl = 0; e_bpv = 0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p]) begin
                    m_dup = 0;
                    for (int q = 0; q < p; q++)
                        if (wb_valid[q] && wb_tag[q*TW +: TW] == wb_tag[p*TW +: TW]) m_dup = 1;
                    if (!m_dup) begin
                        foreach (mq[i]) begin
                            if (mq[i].tag == int'(wb_tag[p*TW +: TW])) begin
                                m_t = mq[i];
                                m_t.ready  = 1;
                                m_t.res    = wb_res[p*XLEN +: XLEN];
                                m_t.taken  = wb_taken[p];
                                m_t.target = wb_target[p*XLEN +: XLEN];
                                mq[i] = m_t;
                            end
                        end
                    end
                end
            end
            if (m_ret) begin
                void'(mq.pop_front());
                if (!m_h.is_st && m_h.rd != 0) begin
                    e_cv = 1; e_crd = m_h.rd; e_cres = m_h.res; e_ctag = m_h.tag;
                end
                if (m_h.is_st) begin
                    e_scv = 1; e_stag = m_h.tag;
                end
                if (m_h.is_br) begin
                    e_bpv = 1; e_bppc = m_h.pc; e_bpt = m_h.taken;
                    if (m_h.taken != m_h.pred) begin
                        e_fl = 1;
                        e_flpc = m_h.taken ? m_h.target : m_h.pc + 32'd4;
                    end
                end
            end
            if (m_can_disp && disp_valid) begin
                m_t = '{tag: m_tail, rd: disp_rd, pc: disp_pc, is_br: disp_is_br,
                        is_st: disp_is_st, pred: disp_pred, ready: 0, taken: 0,
                        res: 32'd0, target: 32'd0};
                mq.push_back(m_t);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    end

    function automatic void look(input logic [TW-1:0] t, output bit r, output logic [31:0] v);
        r = 0;
        v = 0;
        for (int p = 0; p < NUM_WB; p++)
            if (!r && wb_valid[p] && wb_tag[p*TW +: TW] == t) begin
                r = 1;
                v = wb_res[p*XLEN +: XLEN];
            end
        if (!r)
            foreach (mq[i])
                if (mq[i].tag == int'(t) && mq[i].ready) begin
                    r = 1;
                    v = mq[i].res;
                end
    endfunction

    bit          x_r;
    logic [31:0] x_v;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("disp_ready", 64'(disp_ready), 64'(mq.size() < DEPTH && !e_fl));
            chk("disp_tag", 64'(disp_tag), 64'(m_tail));
            look(qj_tag, x_r, x_v);
            chk("qj_rdy", 64'(qj_rdy), 64'(x_r));
            if (x_r) chk("qj_val", 64'(qj_val), 64'(x_v));
            look(qk_tag, x_r, x_v);
            chk("qk_rdy", 64'(qk_rdy), 64'(x_r));
            if (x_r) chk("qk_val", 64'(qk_val), 64'(x_v));
            chk("commit_valid", 64'(commit_valid), 64'(e_cv));
            if (e_cv) begin
                chk("commit_rd", 64'(commit_rd), 64'(e_crd));
                chk("commit_res", 64'(commit_res), 64'(e_cres));
                chk("commit_tag", 64'(commit_tag), 64'(e_ctag));
            end
            chk("st_commit_valid", 64'(st_commit_valid), 64'(e_scv));
            if (e_scv) chk("st_commit_tag", 64'(st_commit_tag), 64'(e_stag));
            chk("flush", 64'(flush), 64'(e_fl));
            if (e_fl) chk("flush_pc", 64'(flush_pc), 64'(e_flpc));
            chk("bp_upd_valid", 64'(bp_upd_valid), 64'(e_bpv));
            if (e_bpv) begin
                chk("bp_upd_pc", 64'(bp_upd_pc), 64'(e_bppc));
                chk("bp_upd_taken", 64'(bp_upd_taken), 64'(e_bpt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 0; disp_is_br = 0; disp_is_st = 0; disp_pred = 0;
        wb_valid = '0; wb_taken = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic disp(input logic [4:0] rd, input logic [31:0] pc,
                        input bit br, input bit st, input bit pred);
        disp_valid = 1; disp_rd = rd; disp_pc = pc;
        disp_is_br = br; disp_is_st = st; disp_pred = pred;
        tick();
        disp_valid = 0;
    endtask

    task automatic wb1(input int port, input logic [3:0] tag, input logic [31:0] res,
                       input bit taken, input logic [31:0] tgt);
        wb_valid[port] = 1;
        wb_tag[port*TW +: TW] = tag;
        wb_res[port*XLEN +: XLEN] = res;
        wb_taken[port] = taken;
        wb_target[port*XLEN +: XLEN] = tgt;
    endtask

    task automatic rand_inputs();
        rst = ($urandom_range(0, 299) == 0);
        rdy = ($urandom_range(0, 9) != 0);
        disp_valid = ($urandom_range(0, 9) < 6);
        disp_rd = 5'($urandom);
        disp_pc = $urandom & 32'hFFFF_FFFC;
        disp_is_br = ($urandom_range(0, 3) == 0);
        disp_is_st = !disp_is_br && ($urandom_range(0, 4) == 0);
        disp_pred = 1'($urandom);
        for (int p = 0; p < NUM_WB; p++) begin
            wb_valid[p] = ($urandom_range(0, 2) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                wb_tag[p*TW +: TW] = TW'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                wb_tag[p*TW +: TW] = TW'($urandom);
            wb_res[p*XLEN +: XLEN] = $urandom;
            wb_taken[p] = 1'($urandom);
            wb_target[p*XLEN +: XLEN] = $urandom & 32'hFFFF_FFFC;
        end
        if ($urandom_range(0, 7) == 0) wb_tag[TW +: TW] = wb_tag[0 +: TW];
        qj_tag = ($urandom_range(0, 2) == 0) ? wb_tag[0 +: TW] : TW'($urandom);
        qk_tag = ($urandom_range(0, 2) == 0) ? wb_tag[TW +: TW] : TW'($urandom);
    endtask

    initial begin
        rst = 1; rdy = 1; idle();
        disp_rd = 0; disp_pc = 0; wb_tag = '0; wb_res = '0; wb_target = '0;
        qj_tag = 0; qk_tag = 0;
        tick();
        chk_on = 1;
        rst = 0;
        tick();
        chk("rst disp_ready", 64'(disp_ready), 64'd1);
        chk("rst disp_tag", 64'(disp_tag), 64'd0);
        chk("rst commit_valid", 64'(commit_valid), 64'd0);

        // Fill the buffer, then forward a same-cycle writeback into a lookup.
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("fill tag15", 64'(disp_tag), 64'd15);
            disp(5'(i + 1), 32'h1000 + 32'(i * 4), 0, 0, 0);
        end
        chk("full disp_ready", 64'(disp_ready), 64'd0);
        chk("full disp_tag", 64'(disp_tag), 64'd0);
        wb1(1, 4'd3, 32'hDEADBEEF, 0, 0);
        qj_tag = 4'd3;
        #1;
        chk("fwd qj_rdy", 64'(qj_rdy), 64'd1);
        chk("fwd qj_val", 64'(qj_val), 64'hDEADBEEF);
        wb1(0, 4'd3, 32'h11111111, 0, 0);
        #1;
        chk("prio qj_val", 64'(qj_val), 64'h11111111);
        tick();
        idle();
        wb1(0, 4'd0, 32'h5, 0, 0);
        tick();
        idle();
        tick();
        chk("wrap disp_ready", 64'(disp_ready), 64'd1);
        chk("wrap disp_tag", 64'(disp_tag), 64'd0);
        disp(5'd9, 32'h2000, 0, 0, 0);
        chk("wrap next tag", 64'(disp_tag), 64'd1);

        // Out-of-order completion, in-order commit.
        do_reset();
        for (int i = 0; i < 3; i++) disp(5'(i + 1), 32'h40 + 32'(i * 4), 0, 0, 0);
        for (int t = 2; t >= 0; t--) begin
            wb1(0, 4'(t), 32'hA0 + 32'(t), 0, 0);
            tick();
            idle();
        end
        chk("ooo no early commit", 64'(commit_valid), 64'd0);
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("ooo commit_valid", 64'(commit_valid), 64'd1);
            chk("ooo commit_tag", 64'(commit_tag), 64'(t));
        end

        // Mispredicted branch: redirect and discard younger entries.
        do_reset();
        disp(5'd0, 32'h100, 1, 0, 0);
        disp(5'd5, 32'h104, 0, 0, 0);
        disp(5'd6, 32'h108, 0, 0, 0);
        wb1(0, 4'd1, 32'h55, 0, 0);
        wb1(1, 4'd2, 32'h66, 0, 0);
        tick();
        idle();
        wb1(0, 4'd0, 32'h0, 1, 32'h200);
        tick();
        idle();
        tick();
        chk("br flush", 64'(flush), 64'd1);
        chk("br flush_pc", 64'(flush_pc), 64'h200);
        chk("br bp_taken", 64'(bp_upd_taken), 64'd1);
        chk("br bp_pc", 64'(bp_upd_pc), 64'h100);
        tick();
        chk("br no young commit", 64'(commit_valid), 64'd0);
        chk("br cleared tag", 64'(disp_tag), 64'd0);
        tick();
        chk("br still no commit", 64'(commit_valid), 64'd0);

        // Store release.
        do_reset();
        disp(5'd7, 32'h300, 0, 1, 0);
        wb1(0, 4'd0, 32'h77, 0, 0);
        tick();
        idle();
        tick();
        chk("st valid", 64'(st_commit_valid), 64'd1);
        chk("st tag", 64'(st_commit_tag), 64'd0);
        chk("st no commit", 64'(commit_valid), 64'd0);

        // Reset with entries in flight.
        for (int i = 0; i < 5; i++) disp(5'(i + 1), 32'h400 + 32'(i * 4), 0, 0, 0);
        do_reset();
        chk("rstmid commit", 64'(commit_valid), 64'd0);
        chk("rstmid flush", 64'(flush), 64'd0);
        chk("rstmid tag", 64'(disp_tag), 64'd0);
        chk("rstmid ready", 64'(disp_ready), 64'd1);

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rand_inputs();
            tick();
        end
        rst = 0; rdy = 1; idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
